led_row_scanner: RTL and testbench

//   Time-multiplexed LED matrix driver, directly downstream of the SUB/AND instance arrays.

---
 rtl/led_row_scanner.sv | 173 +++++++++++++++++
 tb/tb_led_row_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_row_scanner.sv
// led_row_scanner: time-multiplexed LED matrix driver.
// A frame and its brightness are loaded into a shadow buffer through a
// valid/ready port, swapped into the active buffer at frame boundaries, and
// scanned one row at a time with a blanking cycle between rows and
// PWM-dimmed column drive.
module led_row_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int PWM_BITS     = 4,
    parameter int DWELL_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_frame_valid,
    output logic                   o_frame_ready,
    input  logic [ROWS*COLS-1:0]   i_frame_data,
    input  logic [PWM_BITS-1:0]    i_brightness,
    output logic [ROWS-1:0]        o_row_sel,
    output logic [COLS-1:0]        o_col_drv,
    output logic                   o_frame_done,
    output logic                   o_busy
);

    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        BLANK = 2'd2,
        SCAN  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [ROWS*COLS-1:0]   r_shadow;
    logic [PWM_BITS-1:0]    r_shadowDuty;
    logic                   r_shadowFull;
    logic [ROWS*COLS-1:0]   r_active;
    logic [PWM_BITS-1:0]    r_duty;
    logic [ROW_W-1:0]       r_row;
    logic [DWELL_W-1:0]     r_dwell;
    logic [PWM_BITS-1:0]    r_pwm;

    logic [ROWS-1:0]        r_rowSel;
    logic [COLS-1:0]        r_colDrv;
    logic                   r_frameDone;

    logic                   w_accept;
    logic                   w_dwellEnd;
    logic                   w_lastRow;
    logic                   w_pwmOn;
    logic [ROWS-1:0]        w_rowSel;
    logic [COLS-1:0]        w_colDrv;
    logic                   w_frameDone;

    // Ready comes straight from a register, so accept has no
    // combinational path from valid back to ready.
    assign w_accept   = i_frame_valid & ~r_shadowFull;
    assign w_dwellEnd = (r_dwell == DWELL_W'(DWELL_CYCLES - 1));
    assign w_lastRow  = (r_row == ROW_W'(ROWS - 1));
    assign w_pwmOn    = (r_pwm < r_duty);

    assign o_frame_ready = ~r_shadowFull;
    assign o_busy        = (r_state != IDLE);
    assign o_row_sel     = r_rowSel;
    assign o_col_drv     = r_colDrv;
    assign o_frame_done  = r_frameDone;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: swap only at frame boundaries, blank between rows.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (r_shadowFull) w_nextState = SWAP;
            SWAP:    w_nextState = BLANK;
            BLANK:   w_nextState = SCAN;
            SCAN: begin
                if (w_dwellEnd) begin
                    if (w_lastRow && r_shadowFull) w_nextState = SWAP;
                    else                           w_nextState = BLANK;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode: only SCAN lights anything; done marks the last dwell cycle.
    always_comb begin
        w_rowSel    = '0;
        w_colDrv    = '0;
        w_frameDone = 1'b0;
        if (r_state == SCAN) begin
            w_rowSel    = ROWS'(1) << r_row;
            w_colDrv    = r_active[r_row*COLS +: COLS] & {COLS{w_pwmOn}};
            w_frameDone = w_dwellEnd & w_lastRow;
        end
    end

    // Shadow buffer: one pending frame plus its brightness.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow     <= '0;
            r_shadowDuty <= '0;
            r_shadowFull <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow     <= i_frame_data;
                r_shadowDuty <= i_brightness;
            end
            if (w_accept) begin
                r_shadowFull <= 1'b1;
            end else if (r_state == SWAP) begin
                r_shadowFull <= 1'b0;
            end
        end
    end

    // Active buffer and the row / dwell / PWM counters that walk it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= '0;
            r_duty   <= '0;
            r_row    <= '0;
            r_dwell  <= '0;
            r_pwm    <= '0;
        end else begin
            case (r_state)
                SWAP: begin
                    r_active <= r_shadow;
                    r_duty   <= r_shadowDuty;
                    r_row    <= '0;
                end
                BLANK: begin
                    r_dwell <= '0;
                    r_pwm   <= '0;
                end
                SCAN: begin
                    r_dwell <= r_dwell + DWELL_W'(1);
                    r_pwm   <= r_pwm + PWM_BITS'(1);
                    if (w_dwellEnd) begin
                        if (w_lastRow) r_row <= '0;
                        else           r_row <= r_row + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered drive outputs, one cycle behind the state that produced them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rowSel    <= '0;
            r_colDrv    <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_rowSel    <= w_rowSel;
            r_colDrv    <= w_colDrv;
            r_frameDone <= w_frameDone;
        end
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// tb_led_row_scanner: randomized and directed bench for led_row_scanner,
// compared every cycle against a frame-timeline model.
module tb_led_row_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int PBITS  = 4;
    localparam int DWELL  = 64;
    localparam int PWMP   = 1 << PBITS;
    localparam int ROWP   = DWELL + 1;
    localparam int FRAMEP = ROWS * ROWP;

    localparam int M_IDLE = 0;
    localparam int M_SWAP = 1;
    localparam int M_RUN  = 2;

    logic                 clk = 1'b0;
    logic                 rstN = 1'b0;
    logic                 frameValid = 1'b0;
    logic [ROWS*COLS-1:0] frameData = '0;
    logic [PBITS-1:0]     brightness = '0;
    logic                 frameReady;
    logic [ROWS-1:0]      rowSel;
    logic [COLS-1:0]      colDrv;
    logic                 frameDone;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    // Model state: a position on the frame timeline instead of per-row counters.
    int                   mMode = M_IDLE;
    int                   mPos = 0;
    bit                   mFull = 1'b0;
    logic [ROWS*COLS-1:0] mShadow = '0;
    logic [ROWS*COLS-1:0] mActive = '0;
    logic [PBITS-1:0]     mShadowB = '0;
    logic [PBITS-1:0]     mDuty = '0;
    logic [ROWS-1:0]      eRow = '0;
    logic [COLS-1:0]      eCol = '0;
    logic                 eDone = 1'b0;

    led_row_scanner #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PBITS), .DWELL_CYCLES(DWELL)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_frame_valid(frameValid),
        .o_frame_ready(frameReady),
        .i_frame_data(frameData),
        .i_brightness(brightness),
        .o_row_sel(rowSel),
        .o_col_drv(colDrv),
        .o_frame_done(frameDone),
        .o_busy(busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // One comparison: counts it, and reports it on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive the load port just after a falling edge.
    task automatic applyStimulus(input bit v, input logic [ROWS*COLS-1:0] d, input logic [PBITS-1:0] b);
        @(negedge clk);
        #1;
        frameValid = v;
        frameData  = d;
        brightness = b;
    endtask

    // Wait (bounded) for the next frame_done pulse.
    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (frameDone === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    // Model: at each rising edge compute what the registered outputs become
    // from the timeline position, then advance the timeline and the buffers.
    always @(posedge clk) begin : model
        int r;
        int d;
        bit acc;
        if (!rstN) begin
            mMode = M_IDLE; mPos = 0; mFull = 1'b0;
            mShadow = '0; mActive = '0; mShadowB = '0; mDuty = '0;
            eRow = '0; eCol = '0; eDone = 1'b0;
        end else begin
            eRow = '0; eCol = '0; eDone = 1'b0;
            if (mMode == M_RUN && (mPos % ROWP) != 0) begin
                r = mPos / ROWP;
                d = (mPos % ROWP) - 1;
                eRow = ROWS'(1 << r);
                if ((d % PWMP) < int'(mDuty)) eCol = mActive[r*COLS +: COLS];
            end
            if (mMode == M_RUN && mPos == FRAMEP - 1) eDone = 1'b1;
            acc = frameValid && !mFull;
            case (mMode)
                M_IDLE: if (mFull) mMode = M_SWAP;
                M_SWAP: begin
                    mActive = mShadow; mDuty = mShadowB; mFull = 1'b0;
                    mMode = M_RUN; mPos = 0;
                end
                default: begin
                    if (mPos == FRAMEP - 1) begin
                        if (mFull) mMode = M_SWAP;
                        else       mPos = 0;
                    end else begin
                        mPos = mPos + 1;
                    end
                end
            endcase
            if (acc) begin
                mShadow = frameData; mShadowB = brightness; mFull = 1'b1;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("rowSel", 32'(rowSel), 32'(eRow));
            checkOutput("colDrv", 32'(colDrv), 32'(eCol));
            checkOutput("frameDone", 32'(frameDone), 32'(eDone));
            checkOutput("frameReady", 32'(frameReady), 32'(!mFull));
            checkOutput("busy", 32'(busy), 32'(mMode != M_IDLE));
        end
    end

    initial begin : stimulus
        int n;
        int lit;
        int wrongCol;
        int blanks;
        logic [COLS-1:0] colOr;
        logic [ROWS-1:0] rowOr;
        bit found;

        // Reset held with valid asserted: nothing may be accepted.
        rstN = 1'b0; frameValid = 1'b1; frameData = 16'h8421; brightness = 4'd15;
        @(posedge clk);
        #1 cmpEn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstReady", 32'(frameReady), 32'd1);
            checkOutput("rstRowSel", 32'(rowSel), 32'd0);
            checkOutput("rstColDrv", 32'(colDrv), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
        end
        #1 rstN = 1'b1;
        applyStimulus(1'b0, 16'h8421, 4'd15);

        // Diagonal frame at full brightness: frame period, blanking, duty.
        waitDone();
        n = 0; lit = 0; wrongCol = 0; blanks = 0;
        do begin
            @(negedge clk);
            n++;
            if (rowSel == 4'b0100 && colDrv == 4'h4) lit++;
            if (rowSel == 4'b0100 && colDrv != 4'h4 && colDrv != 4'h0) wrongCol++;
            if (rowSel == 4'b0001 && colDrv != 4'h1 && colDrv != 4'h0) wrongCol++;
            if (rowSel == 4'b0000) blanks++;
        end while (frameDone !== 1'b1 && n < 1000);
        checkOutput("framePeriod", 32'(n), 32'd260);
        checkOutput("row2LitCycles", 32'(lit), 32'd60);
        checkOutput("diagWrongCol", 32'(wrongCol), 32'd0);
        checkOutput("blankCycles", 32'(blanks), 32'd4);

        // All-on frame at zero brightness, loaded mid-scan: swap adds a cycle, nothing lights.
        applyStimulus(1'b1, 16'hFFFF, 4'd0);
        checkOutput("acceptReady", 32'(frameReady), 32'd1);
        applyStimulus(1'b0, 16'h0000, 4'd0);
        checkOutput("pendingReady", 32'(frameReady), 32'd0);
        waitDone();
        n = 0; colOr = '0; rowOr = '0;
        do begin
            @(negedge clk);
            n++;
            colOr |= colDrv;
            rowOr |= rowSel;
        end while (frameDone !== 1'b1 && n < 1000);
        checkOutput("swapFramePeriod", 32'(n), 32'd261);
        checkOutput("darkColOr", 32'(colOr), 32'd0);
        checkOutput("rowsSeen", 32'(rowOr), 32'hF);

        // Frame A then B back to back: B must wait for ready.
        applyStimulus(1'b1, 16'h1234, 4'd9);
        applyStimulus(1'b1, 16'hBEEF, 4'd5);
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (frameReady === 1'b1) found = 1'b1;
        end
        if (!found) checkOutput("readyTimeout", 32'd0, 32'd1);
        applyStimulus(1'b0, 16'h0000, 4'd0);
        repeat (600) @(negedge clk);

        // Random loads with random brightness.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 8) == 0, 16'($urandom),
                          (($urandom % 4) == 0) ? 4'(($urandom % 2) * 15) : 4'($urandom));
        end
        applyStimulus(1'b0, 16'h0000, 4'd0);

        // Reset while row 2 is lit aborts everything.
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (rowSel === 4'b0100) found = 1'b1;
        end
        if (!found) checkOutput("row2Timeout", 32'd0, 32'd1);
        #1 rstN = 1'b0;
        @(negedge clk);
        checkOutput("abortRowSel", 32'(rowSel), 32'd0);
        checkOutput("abortColDrv", 32'(colDrv), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortReady", 32'(frameReady), 32'd1);
        #1 rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleRowSel", 32'(rowSel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
